// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : cpu_pkg
//  Purpose : Shared decode constants: destination-select encodings, fixed
//            register indices and instruction field positions.
//  Revision: 1.0  initial release
// ============================================================================
package cpu_pkg;

  // Destination register source select, as driven by the control unit.
  typedef enum logic [2:0] {
    DST_RT   = 3'd0,
    DST_RD   = 3'd1,
    DST_SP   = 3'd2,
    DST_LINK = 3'd3,
    DST_RS   = 3'd4
  } dst_sel_e;

  // Fixed architectural registers.
  localparam int unsigned SP_REG   = 29;
  localparam int unsigned LINK_REG = 31;

  // Register-index field positions within the instruction word.
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RD_LSB  = 11;
  localparam int unsigned FIELD_W = 5;

endpackage
`default_nettype wire

// File: rtl/dest_sel_mux.sv
`default_nettype none
// ============================================================================
//  Module  : dest_sel_mux
//  Purpose : Combinational destination-register selector. Picks the write
//            destination from an instruction field or a fixed register and
//            flags encodings that name no destination.
//  Ports   : instr   [31:0]      decoded instruction word
//            reg_sel [2:0]       destination source select
//            legal               reg_sel is a defined encoding
//            dest    [REG_AW-1:0] selected destination index (0 when illegal)
//  Revision: 1.0  initial release
// ============================================================================
module dest_sel_mux
  import cpu_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int SP_IDX   = 29,
  parameter int LINK_IDX = 31
) (
  input  logic [31:0]       instr,
  input  logic [2:0]        reg_sel,
  output logic              legal,
  output logic [REG_AW-1:0] dest
);

  // Instruction fields are 5 bits wide; they are zero-extended into the
  // index width so a wider register file never sees stray upper bits.
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [REG_AW-1:0] w_rd;

  assign w_rs = REG_AW'(instr[RS_LSB +: FIELD_W]);
  assign w_rt = REG_AW'(instr[RT_LSB +: FIELD_W]);
  assign w_rd = REG_AW'(instr[RD_LSB +: FIELD_W]);

  // Opcode and function bits play no part in destination selection.
  logic w_unused_instr;
  assign w_unused_instr = &{1'b0, instr[31:26], instr[10:0]};

  always_comb begin
    legal = 1'b1;
    dest  = '0;
    case (reg_sel)
      DST_RT:   dest = w_rt;
      DST_RD:   dest = w_rd;
      DST_SP:   dest = REG_AW'(SP_IDX);
      DST_LINK: dest = REG_AW'(LINK_IDX);
      DST_RS:   dest = w_rs;
      default:  legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/reg_dest_queue.sv
`default_nettype none
// ============================================================================
//  Module  : reg_dest_queue
//  Purpose : In-order queue of write-back destination indices between decode
//            and the register-file write port, with a per-register count of
//            pending writes used to raise RAW hazards on two source operands.
//  Ports   : clk, reset (async, active-low)
//            instr, reg_sel, push_valid / push_ready   decode-side enqueue
//            sel_err                                   illegal select pulse
//            pop_valid, pop_ready, pop_dest            write-back dequeue
//            rs_q, rt_q / hazard_a, hazard_b           hazard lookup
//            flush                                     synchronous clear
//            count                                     occupied entries
//  Revision: 1.0  initial release
// ============================================================================
module reg_dest_queue #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 4,
  parameter int SP_REG   = cpu_pkg::SP_REG,
  parameter int LINK_REG = cpu_pkg::LINK_REG
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              instr,
  input  logic [2:0]               reg_sel,
  input  logic                     push_valid,
  output logic                     push_ready,
  output logic                     sel_err,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [REG_AW-1:0]        pop_dest,
  input  logic [REG_AW-1:0]        rs_q,
  input  logic [REG_AW-1:0]        rt_q,
  output logic                     hazard_a,
  output logic                     hazard_b,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  import cpu_pkg::*;

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH) + 1;
  localparam int c_nreg  = 2 ** REG_AW;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

  // ---------------------------------------------------------------------------
  // Destination select
  // ---------------------------------------------------------------------------
  logic              w_legal;
  logic [REG_AW-1:0] w_dest;

  dest_sel_mux #(
    .REG_AW   (REG_AW),
    .SP_IDX   (SP_REG),
    .LINK_IDX (LINK_REG)
  ) u_dest_sel_mux (
    .instr   (instr),
    .reg_sel (reg_sel),
    .legal   (w_legal),
    .dest    (w_dest)
  );

  // ---------------------------------------------------------------------------
  // Queue state
  // ---------------------------------------------------------------------------
  logic [REG_AW-1:0]  r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_cnt_w-1:0] r_count;
  logic               r_sel_err;
  logic [c_cnt_w-1:0] r_pend [c_nreg];

  logic              w_push_try;
  logic              w_push;
  logic              w_pop;
  logic [REG_AW-1:0] w_head;

  // Readiness comes only from the registered count, so a full queue refuses
  // a push even when the head is leaving in the same cycle.
  assign push_ready = (r_count != c_full);
  assign pop_valid  = (r_count != '0);
  assign w_head     = r_mem[r_rptr];
  assign pop_dest   = pop_valid ? w_head : '0;
  assign count      = r_count;
  assign sel_err    = r_sel_err;

  assign w_push_try = push_valid & push_ready;
  assign w_push     = w_push_try & w_legal & ~flush;
  assign w_pop      = pop_valid & pop_ready & ~flush;

  // Storage carries no reset: stale entries are never observed because
  // pop_dest is masked by pop_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_dest;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // An illegal select is reported even in a flush cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= w_push_try & ~w_legal;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-write scoreboard
  // ---------------------------------------------------------------------------
  logic [c_nreg-1:0] w_inc;
  logic [c_nreg-1:0] w_dec;

  // Register 0 is hardwired to zero: it never gains a pending count, and so
  // its pop must not decrement either.
  assign w_inc[0] = 1'b0;
  assign w_dec[0] = 1'b0;

  for (genvar r = 1; r < c_nreg; r++) begin : g_pend_dec
    assign w_inc[r] = w_push && (w_dest == REG_AW'(r));
    assign w_dec[r] = w_pop  && (w_head == REG_AW'(r));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < c_nreg; r++) begin
        r_pend[r] <= '0;
      end
    end else begin
      for (int r = 0; r < c_nreg; r++) begin
        if (flush) begin
          r_pend[r] <= '0;
        end else if (w_inc[r] && !w_dec[r]) begin
          r_pend[r] <= r_pend[r] + 1'b1;
        end else if (w_dec[r] && !w_inc[r]) begin
          r_pend[r] <= r_pend[r] - 1'b1;
        end
      end
    end
  end

  assign hazard_a = (r_pend[rs_q] != '0);
  assign hazard_b = (r_pend[rt_q] != '0);

endmodule
`default_nettype wire

// File: tb/tb_reg_dest_queue.sv
`default_nettype none
// ============================================================================
//  Module  : tb_reg_dest_queue
//  Purpose : Directed self-checking bench for reg_dest_queue. Accepted pushes
//            enqueue their hand-computed destination in a scoreboard; a
//            monitor pops and compares on every dequeue handshake.
//  Revision: 1.0  initial release
// ============================================================================
module tb_reg_dest_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic [2:0]  reg_sel;
  logic        push_valid;
  logic        push_ready;
  logic        sel_err;
  logic        pop_valid;
  logic        pop_ready;
  logic [4:0]  pop_dest;
  logic [4:0]  rs_q;
  logic [4:0]  rt_q;
  logic        hazard_a;
  logic        hazard_b;
  logic        flush;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;
  logic [4:0] exp_q[$];

  reg_dest_queue #(
    .REG_AW   (5),
    .DEPTH    (4),
    .SP_REG   (29),
    .LINK_REG (31)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .reg_sel    (reg_sel),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .sel_err    (sel_err),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_dest   (pop_dest),
    .rs_q       (rs_q),
    .rt_q       (rt_q),
    .hazard_a   (hazard_a),
    .hazard_b   (hazard_b),
    .flush      (flush),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int rs, input int rt, input int rd);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  // One clock of stimulus; acc says whether the push is expected to be taken.
  task automatic step(input logic pv, input logic [2:0] sel, input logic [31:0] ins,
                      input logic pr, input logic fl, input logic acc, input logic [4:0] d);
    push_valid = pv;
    reg_sel    = sel;
    instr      = ins;
    pop_ready  = pr;
    flush      = fl;
    if (fl) exp_q.delete();
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    flush      = 1'b0;
    reg_sel    = 3'd0;
    instr      = 32'd0;
  endtask

  task automatic push(input logic [2:0] sel, input logic [31:0] ins, input logic [4:0] d);
    step(1'b1, sel, ins, 1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic pop();
    step(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic lookup(input logic [4:0] a, input logic [4:0] b);
    rs_q = a;
    rt_q = b;
    #1;
  endtask

  // Scoreboard monitor: every dequeue handshake must match the oldest expected.
  always @(negedge clk) begin
    if (reset && !flush && pop_ready) begin
      if (!pop_valid) begin
        if (exp_q.size() != 0) check("pop_empty", 32'(pop_valid), 32'd1);
      end else if (exp_q.size() == 0) begin
        check("pop_unexpected", 32'(pop_dest), 32'd0 - 32'd1);
      end else begin
        check("pop_dest", 32'(pop_dest), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; instr = '0; reg_sel = '0; push_valid = 1'b0;
    pop_ready = 1'b0; rs_q = '0; rt_q = '0; flush = 1'b0;
    #12;
    check("rst_count",      32'(count),      32'd0);
    check("rst_pop_valid",  32'(pop_valid),  32'd0);
    check("rst_pop_dest",   32'(pop_dest),   32'd0);
    check("rst_sel_err",    32'(sel_err),    32'd0);
    check("rst_push_ready", 32'(push_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;

    // 1: reset mid-traffic
    push(3'd1, mk(0, 0, 1), 5'd1);
    push(3'd1, mk(0, 0, 2), 5'd2);
    push(3'd1, mk(0, 0, 3), 5'd3);
    lookup(5'd1, 5'd3);
    check("t1_count3",  32'(count),    32'd3);
    check("t1_haz_a",   32'(hazard_a), 32'd1);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("t1_rst_count",  32'(count),      32'd0);
    check("t1_rst_pvalid", 32'(pop_valid),  32'd0);
    check("t1_rst_haz_a",  32'(hazard_a),   32'd0);
    check("t1_rst_haz_b",  32'(hazard_b),   32'd0);
    check("t1_rst_pready", 32'(push_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;

    // 2: RD then LINK; hazard on 8 until it leaves
    lookup(5'd8, 5'd31);
    push(3'd1, mk(0, 0, 8), 5'd8);
    check("t2_pvalid",   32'(pop_valid), 32'd1);
    check("t2_head",     32'(pop_dest),  32'd8);
    check("t2_haz_a8",   32'(hazard_a),  32'd1);
    push(3'd3, mk(3, 4, 5), 5'd31);
    check("t2_haz_b31",  32'(hazard_b),  32'd1);
    pop();
    check("t2_haz_a8_clr", 32'(hazard_a), 32'd0);
    check("t2_haz_b31_on", 32'(hazard_b), 32'd1);
    pop();
    check("t2_empty_dest", 32'(pop_dest),  32'd0);
    check("t2_haz_b31_clr", 32'(hazard_b), 32'd0);

    // 3: full queue refuses a push even while popping
    push(3'd1, mk(0, 0, 10), 5'd10);
    push(3'd1, mk(0, 0, 11), 5'd11);
    push(3'd1, mk(0, 0, 12), 5'd12);
    push(3'd1, mk(0, 0, 13), 5'd13);
    check("t3_full_ready", 32'(push_ready), 32'd0);
    check("t3_full_count", 32'(count),      32'd4);
    step(1'b1, 3'd1, mk(0, 0, 14), 1'b1, 1'b0, 1'b0, 5'd0);
    check("t3_count3",     32'(count),      32'd3);
    lookup(5'd14, 5'd13);
    check("t3_no14",       32'(hazard_a),   32'd0);
    check("t3_13pend",     32'(hazard_b),   32'd1);
    pop(); pop(); pop();
    check("t3_drained",    32'(count),      32'd0);

    // 4: two pending writes to r5
    lookup(5'd0, 5'd5);
    push(3'd0, mk(0, 5, 0), 5'd5);
    push(3'd0, mk(0, 5, 0), 5'd5);
    pop();
    check("t4_haz_b_one",  32'(hazard_b), 32'd1);
    pop();
    check("t4_haz_b_none", 32'(hazard_b), 32'd0);

    // 5: same-cycle push and pop of r7; then r0 and fixed/RS selects
    lookup(5'd7, 5'd0);
    push(3'd1, mk(0, 0, 7), 5'd7);
    step(1'b1, 3'd1, mk(0, 0, 7), 1'b1, 1'b0, 1'b1, 5'd7);
    check("t5_haz7",     32'(hazard_a), 32'd1);
    check("t5_count1",   32'(count),    32'd1);
    pop();
    check("t5_haz7_clr", 32'(hazard_a), 32'd0);
    push(3'd0, mk(9, 0, 9), 5'd0);
    lookup(5'd0, 5'd0);
    check("t5_r0_count", 32'(count),    32'd1);
    check("t5_r0_haz_a", 32'(hazard_a), 32'd0);
    check("t5_r0_haz_b", 32'(hazard_b), 32'd0);
    push(3'd2, mk(1, 2, 3), 5'd29);
    push(3'd4, mk(17, 2, 3), 5'd17);
    lookup(5'd29, 5'd17);
    check("t5_sp_haz",   32'(hazard_a), 32'd1);
    check("t5_rs_haz",   32'(hazard_b), 32'd1);
    pop(); pop(); pop();
    check("t5_drained",  32'(count),    32'd0);

    // 6: illegal select, then flush
    step(1'b1, 3'd6, mk(1, 2, 3), 1'b0, 1'b0, 1'b0, 5'd0);
    check("t6_sel_err",     32'(sel_err), 32'd1);
    check("t6_nothing_q",   32'(count),   32'd0);
    @(posedge clk); #1;
    check("t6_sel_err_off", 32'(sel_err), 32'd0);
    push(3'd1, mk(0, 0, 3), 5'd3);
    push(3'd1, mk(0, 0, 4), 5'd4);
    check("t6_count2",      32'(count),   32'd2);
    step(1'b1, 3'd1, mk(0, 0, 9), 1'b0, 1'b1, 1'b0, 5'd0);
    lookup(5'd3, 5'd4);
    check("t6_fl_count",    32'(count),     32'd0);
    check("t6_fl_pvalid",   32'(pop_valid), 32'd0);
    check("t6_fl_haz_a",    32'(hazard_a),  32'd0);
    check("t6_fl_haz_b",    32'(hazard_b),  32'd0);
    lookup(5'd9, 5'd9);
    check("t6_fl_no9",      32'(hazard_a),  32'd0);
    push(3'd1, mk(0, 0, 5), 5'd5);
    step(1'b1, 3'd7, mk(0, 0, 6), 1'b0, 1'b1, 1'b0, 5'd0);
    check("t6_fl_sel_err",  32'(sel_err),   32'd1);
    check("t6_fl_count0",   32'(count),     32'd0);

    @(posedge clk); #1;
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
